dense_layer: RTL and testbench
==============================

// Module: dense_layer
// PURPOSE
//  Fully-connected (dense) classifier stage. It sits directly downstream of the flattening stage
//  and consumes its flattened feature vector. For each output class it computes a multiply-accumulate
//  of the vector against signed weights streamed from an external weight ROM (one product per cycle),
//  then selects the winning class (argmax). Handshake is start/busy/done toward the top-level controller.
// PARAMETERS
//  FLATTENED_LENGTH        1000  elements in flattened vector (NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH)
//  NUM_CLASSES             10    output classes / weight rows
//  CONVOLUTION_DATA_WIDTH  8     activation width; unsigned (post-ReLU/pool)
//  WEIGHT_WIDTH            8     weight width; signed two's complement
//  ACC_WIDTH               32    signed accumulator / dense_out width
//  WEIGHT_ADDR_WIDTH       $clog2(NUM_CLASSES*FLATTENED_LENGTH)  derived localparam
// PORTS
//  clock              in   1                    single clock, rising edge
//  reset              in   1                    synchronous, active-high
//  dense_start        in   1                    1-cycle request; sampled only in IDLE
//  flattened_outfmap  in   [CDW-1:0] x FLATTENED_LENGTH  vector; upstream holds stable while busy=1
//  weight_rd_en       out  1                    ROM read strobe
//  weight_addr        out  WEIGHT_ADDR_WIDTH    row-major: class*FLATTENED_LENGTH + idx
//  weight_data        in   WEIGHT_WIDTH         ROM data, valid exactly 1 cycle after rd_en/addr
//  busy               out  1                    high in every non-IDLE state
//  dense_done         out  1                    1-cycle pulse; outputs valid from this cycle until next start
//  dense_out          out  ACC_WIDTH x NUM_CLASSES  signed class scores
//  predicted_class    out  $clog2(NUM_CLASSES)  argmax index
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; busy, dense_done, weight_rd_en = 0; weight_addr = 0;
//   dense_out[*] = 0; predicted_class = 0; counters and accumulator cleared. Reset mid-operation
//   aborts immediately with the same values. No partial results are retained.
//  FSM: IDLE -> MAC -> DRAIN -> (MAC | ARGMAX) -> DONE -> IDLE.
//   IDLE: dense_start=1 -> MAC with class=0, idx=0, acc=0.
//   MAC: rd_en=1, addr=class*L+idx; idx++ per cycle. A 1-cycle valid pipe adds
//     flattened_outfmap[idx_d] * weight_data to acc on the cycle data returns. After idx=L-1 -> DRAIN.
//   DRAIN: rd_en=0; last product accumulated; dense_out[class] <= final sum.
//     If class<NUM_CLASSES-1: class++, idx=0, acc=0 -> MAC. Otherwise -> ARGMAX.
//   ARGMAX: one class compared per cycle (NUM_CLASSES cycles); signed strict greater-than.
//     Ties resolve to the lowest index. The result is written to predicted_class on exit.
//   DONE: dense_done=1 for exactly 1 cycle -> IDLE.
//  Latency: start sampled at edge k gives dense_done high in cycle k+1+C*(L+1)+C
//   (defaults: k+10021). weight_addr sequence is exactly 0..C*L-1, contiguous, no repeats.
//  Arithmetic: activation zero-extended, weight sign-extended, product signed CDW+WW+1 bits,
//   sign-extended into ACC_WIDTH. No saturation: default worst case |255*-128*1000| < 2^25.
//   Integrators must ensure ACC_WIDTH >= CDW+WW+1+$clog2(L).
//  dense_start while busy: ignored (no queueing). dense_start and reset together: reset wins.
//  dense_out entries for classes not yet processed keep their previous-run values until overwritten.
// STRUCTURE
//  Shared package cnn_pkg: CONVOLUTION_DATA_WIDTH, WEIGHT_WIDTH, ACC_WIDTH defaults,
//   dense_state_t enum {IDLE,MAC,DRAIN,ARGMAX,DONE}, and the FLATTENED_LENGTH derivation.
//  One sub-module, dense_mac: registered signed multiply plus accumulate with clear/enable,
//   ACC_WIDTH result. FSM, counters, ROM interface and argmax stay in dense_layer.
// TESTING (bench: L=4, C=3 unless noted; behavioural ROM with 1-cycle latency)
//  1 act=[1,1,1,1], all weights=+1 -> dense_out=[4,4,4]; predicted_class=0 (tie); done at k+1+15+3=k+19.
//  2 act=[1,2,3,4], rows +1/-1/+2 -> dense_out=[10,-10,20]; predicted_class=2; addr 0..11 in order.
//  3 Defaults L=1000,C=10: act all 255, weights all -128 -> every dense_out=-32640000; class 0; done at k+10021.
//  4 Pulse dense_start again mid-MAC -> ignored; exactly one done pulse; results as in scenario 2.
//  5 Assert reset during class 1 MAC -> next cycle IDLE, busy=0, dense_out all 0; restart gives scenario 2 results.
//  6 All-zero weights except row 1 idx 3 = +1, act[3]=7 -> dense_out=[0,7,0]; predicted_class=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN widths, flattened-length derivation and dense-stage state type
package cnn_pkg;
    localparam int NUM_FEATURES           = 10;
    localparam int POOLED_HEIGHT          = 10;
    localparam int POOLED_WIDTH           = 10;
    localparam int FLATTENED_LENGTH       = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH;
    localparam int NUM_CLASSES            = 10;
    localparam int CONVOLUTION_DATA_WIDTH = 8;
    localparam int WEIGHT_WIDTH           = 8;
    localparam int ACC_WIDTH              = 32;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        ARGMAX,
        DONE
    } dense_state_t;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dense_mac.sv
// rtl/dense_mac.sv - unsigned-activation x signed-weight multiply with clearable accumulator
module dense_mac #(
    parameter int CDW = cnn_pkg::CONVOLUTION_DATA_WIDTH,
    parameter int WW  = cnn_pkg::WEIGHT_WIDTH,
    parameter int ACC = cnn_pkg::ACC_WIDTH
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_clear,
    input  logic           i_en,
    input  logic [CDW-1:0] i_act,
    input  logic [WW-1:0]  i_weight,
    output logic [ACC-1:0] o_sum
);
    localparam int PW = CDW + WW + 1;

    logic signed [PW-1:0]  w_act_s;
    logic signed [PW-1:0]  w_weight_s;
    logic signed [PW-1:0]  w_prod;
    logic signed [ACC-1:0] w_prod_ext;
    logic signed [ACC-1:0] r_acc;

    assign w_act_s    = {{(PW-CDW){1'b0}}, i_act};
    assign w_weight_s = {{(PW-WW){i_weight[WW-1]}}, i_weight};
    assign w_prod     = w_act_s * w_weight_s;
    assign w_prod_ext = {{(ACC-PW){w_prod[PW-1]}}, w_prod};

    // o_sum already includes the product arriving this cycle so the caller can capture a row total on its last beat.
    assign o_sum = r_acc + (i_en ? w_prod_ext : '0);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end
endmodule

// File: rtl/dense_layer.sv
// rtl/dense_layer.sv - dense classifier: per-class MAC over streamed ROM weights, then argmax
module dense_layer #(
    parameter int FLATTENED_LENGTH       = cnn_pkg::FLATTENED_LENGTH,
    parameter int NUM_CLASSES            = cnn_pkg::NUM_CLASSES,
    parameter int CONVOLUTION_DATA_WIDTH = cnn_pkg::CONVOLUTION_DATA_WIDTH,
    parameter int WEIGHT_WIDTH           = cnn_pkg::WEIGHT_WIDTH,
    parameter int ACC_WIDTH              = cnn_pkg::ACC_WIDTH,
    localparam int WEIGHT_ADDR_WIDTH     = $clog2(NUM_CLASSES * FLATTENED_LENGTH),
    localparam int CLASS_WIDTH           = $clog2(NUM_CLASSES)
) (
    input  logic                                             i_clock,
    input  logic                                             i_reset,
    input  logic                                             i_dense_start,
    input  logic [CONVOLUTION_DATA_WIDTH*FLATTENED_LENGTH-1:0] i_flattened_outfmap,
    output logic                                             o_weight_rd_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0]                     o_weight_addr,
    input  logic [WEIGHT_WIDTH-1:0]                          i_weight_data,
    output logic                                             o_busy,
    output logic                                             o_dense_done,
    output logic [ACC_WIDTH*NUM_CLASSES-1:0]                 o_dense_out,
    output logic [CLASS_WIDTH-1:0]                           o_predicted_class
);
    import cnn_pkg::*;

    localparam int                     CDW       = CONVOLUTION_DATA_WIDTH;
    localparam int                     IDX_WIDTH = counter_width(FLATTENED_LENGTH);
    localparam logic [IDX_WIDTH-1:0]   IDX_LAST  = IDX_WIDTH'(FLATTENED_LENGTH - 1);
    localparam logic [CLASS_WIDTH-1:0] CLS_LAST  = CLASS_WIDTH'(NUM_CLASSES - 1);

    dense_state_t                   r_state;
    logic [CLASS_WIDTH-1:0]         r_class;
    logic [IDX_WIDTH-1:0]           r_idx;
    logic [IDX_WIDTH-1:0]           r_idx_d;
    logic                           r_valid;
    logic                           r_rd_en;
    logic [WEIGHT_ADDR_WIDTH-1:0]   r_addr;
    logic                           r_busy;
    logic                           r_done;
    logic signed [ACC_WIDTH-1:0]    r_scores [NUM_CLASSES];
    logic [CLASS_WIDTH-1:0]         r_arg_idx;
    logic signed [ACC_WIDTH-1:0]    r_best_val;
    logic [CLASS_WIDTH-1:0]         r_best_idx;
    logic [CLASS_WIDTH-1:0]         r_pred;

    logic [CDW-1:0]                 w_act_arr [FLATTENED_LENGTH];
    logic [CDW-1:0]                 w_act;
    logic                           w_clear;
    logic [ACC_WIDTH-1:0]           w_sum;
    logic signed [ACC_WIDTH-1:0]    w_cand;
    logic                           w_take;
    logic [CLASS_WIDTH-1:0]         w_win_idx;

    for (genvar g = 0; g < FLATTENED_LENGTH; g++) begin : g_act
        assign w_act_arr[g] = i_flattened_outfmap[g*CDW +: CDW];
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_out
        assign o_dense_out[g*ACC_WIDTH +: ACC_WIDTH] = r_scores[g];
    end

    // The ROM answers one cycle late, so the activation is picked with the delayed index.
    assign w_act   = w_act_arr[r_idx_d];
    assign w_clear = (r_state == IDLE) || (r_state == DRAIN);

    dense_mac #(
        .CDW (CDW),
        .WW  (WEIGHT_WIDTH),
        .ACC (ACC_WIDTH)
    ) u_mac (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_clear),
        .i_en     (r_valid),
        .i_act    (w_act),
        .i_weight (i_weight_data),
        .o_sum    (w_sum)
    );

    // Strict greater-than keeps the earliest class on ties.
    assign w_cand    = r_scores[r_arg_idx];
    assign w_take    = (r_arg_idx == '0) || (w_cand > r_best_val);
    assign w_win_idx = w_take ? r_arg_idx : r_best_idx;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_class    <= '0;
            r_idx      <= '0;
            r_idx_d    <= '0;
            r_valid    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_arg_idx  <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_pred     <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_scores[i] <= '0;
            end
        end else begin
            r_valid <= r_rd_en;
            r_idx_d <= r_idx;
            case (r_state)
                IDLE: begin
                    if (i_dense_start) begin
                        r_state <= MAC;
                        r_class <= '0;
                        r_idx   <= '0;
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                MAC: begin
                    r_addr <= r_addr + WEIGHT_ADDR_WIDTH'(1);
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + IDX_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    r_scores[r_class] <= w_sum;
                    if (r_class == CLS_LAST) begin
                        r_arg_idx <= '0;
                        r_state   <= ARGMAX;
                    end else begin
                        r_class <= r_class + CLASS_WIDTH'(1);
                        r_rd_en <= 1'b1;
                        r_state <= MAC;
                    end
                end
                ARGMAX: begin
                    if (w_take) begin
                        r_best_val <= w_cand;
                        r_best_idx <= r_arg_idx;
                    end
                    if (r_arg_idx == CLS_LAST) begin
                        r_pred  <= w_win_idx;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_arg_idx <= r_arg_idx + CLASS_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_weight_rd_en    = r_rd_en;
    assign o_weight_addr     = r_addr;
    assign o_busy            = r_busy;
    assign o_dense_done      = r_done;
    assign o_predicted_class = r_pred;
endmodule

// File: tb/tb_dense_layer.sv
// tb/tb_dense_layer.sv - scoreboard bench for dense_layer (small L=4/C=3 and default-size instance)
module tb_dense_layer;
    localparam int L    = 4;
    localparam int C    = 3;
    localparam int CDW  = 8;
    localparam int WW   = 8;
    localparam int ACC  = 32;
    localparam int WAW  = $clog2(L*C);
    localparam int BL   = 1000;
    localparam int BC   = 10;
    localparam int BWAW = $clog2(BL*BC);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic [CDW*L-1:0]   fmap;
    logic               rd_en;
    logic [WAW-1:0]     addr;
    logic [WW-1:0]      wdata;
    logic               busy;
    logic               done;
    logic [ACC*C-1:0]   dout;
    logic [1:0]         pcls;

    logic               b_start;
    logic [CDW*BL-1:0]  b_fmap;
    logic               b_rd_en;
    logic [BWAW-1:0]    b_addr;
    logic [WW-1:0]      b_wdata;
    logic               b_busy;
    logic               b_done;
    logic [ACC*BC-1:0]  b_dout;
    logic [3:0]         b_pcls;

    dense_layer #(.FLATTENED_LENGTH(L), .NUM_CLASSES(C)) dut (
        .i_clock(clk), .i_reset(rst), .i_dense_start(start), .i_flattened_outfmap(fmap),
        .o_weight_rd_en(rd_en), .o_weight_addr(addr), .i_weight_data(wdata),
        .o_busy(busy), .o_dense_done(done), .o_dense_out(dout), .o_predicted_class(pcls)
    );

    dense_layer dut_big (
        .i_clock(clk), .i_reset(rst), .i_dense_start(b_start), .i_flattened_outfmap(b_fmap),
        .o_weight_rd_en(b_rd_en), .o_weight_addr(b_addr), .i_weight_data(b_wdata),
        .o_busy(b_busy), .o_dense_done(b_done), .o_dense_out(b_dout), .o_predicted_class(b_pcls)
    );

    int w_rom [L*C];
    int act   [L];

    // Behavioural ROMs: one-cycle latency, garbage when not read.
    always @(posedge clk) begin
        wdata   <= rd_en   ? 8'(w_rom[addr]) : 8'($urandom);
        b_wdata <= b_rd_en ? 8'h80           : 8'($urandom);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    longint exp_score_q [$];
    int     exp_cls_q   [$];
    int     done_cnt = 0;
    int     addr_log [$];

    always @(negedge clk) begin
        if (rd_en) addr_log.push_back(int'(addr));
        if (!rst && done) begin
            done_cnt++;
            check("sb_pending", exp_cls_q.size() > 0, 1);
            if (exp_cls_q.size() > 0) begin
                for (int c = 0; c < C; c++) begin
                    check($sformatf("sb_score%0d", c), longint'($signed(dout[c*ACC +: ACC])), exp_score_q.pop_front());
                end
                check("sb_class", pcls, exp_cls_q.pop_front());
            end
        end
    end

    task automatic load_act();
        for (int i = 0; i < L; i++) fmap[i*CDW +: CDW] = 8'(act[i]);
    endtask

    task automatic set_rows(input int r0, input int r1, input int r2);
        for (int i = 0; i < L; i++) begin
            w_rom[0*L+i] = r0;
            w_rom[1*L+i] = r1;
            w_rom[2*L+i] = r2;
        end
    endtask

    task automatic run_case(input string tag, input int mid_pulse);
        longint s;
        longint best_s;
        int     best;
        int     n;
        int     d0;
        best = 0;
        best_s = 0;
        for (int c = 0; c < C; c++) begin
            s = 0;
            for (int i = 0; i < L; i++) s += longint'(act[i]) * longint'(w_rom[c*L+i]);
            exp_score_q.push_back(s);
            if (c == 0 || s > best_s) begin
                best_s = s;
                best   = c;
            end
        end
        exp_cls_q.push_back(best);
        load_act();
        addr_log.delete();
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            start = (n == mid_pulse);
        end
        start = 1'b0;
        check({tag, "_latency"}, n, 1 + C*(L+1) + C);
        repeat (5) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; b_start = 1'b0;
        fmap = '0; b_fmap = '0;
        for (int i = 0; i < L*C; i++) w_rom[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_addr", addr, 0);
        check("rst_dout", dout == '0, 1);
        check("rst_pcls", pcls, 0);
        check("rst_big_busy", b_busy, 0);

        // Reset and start together: reset wins.
        start = 1'b1;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Scenario 1: tie -> class 0
        act = '{1, 1, 1, 1};
        set_rows(1, 1, 1);
        run_case("s1", 0);

        // Scenario 2: mixed signs, address order
        act = '{1, 2, 3, 4};
        set_rows(1, -1, 2);
        run_case("s2", 0);
        check("s2_addr_count", addr_log.size(), C*L);
        for (int i = 0; i < addr_log.size(); i++) check($sformatf("s2_addr%0d", i), addr_log[i], i);

        // Scenario 4: extra start mid-MAC is ignored
        run_case("s4", 6);

        // Scenario 5: reset during class-1 MAC
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        check("s5_mid_busy", busy, 1);
        check("s5_mid_class1_addr", (addr >= L) && (addr < 2*L), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_busy", busy, 0);
        check("s5_rd_en", rd_en, 0);
        check("s5_addr", addr, 0);
        check("s5_dout_zero", dout == '0, 1);
        check("s5_pcls", pcls, 0);
        repeat (3) @(negedge clk);
        check("s5_still_idle", busy, 0);
        run_case("s5_restart", 0);

        // Scenario 6: single nonzero weight
        act = '{5, 5, 5, 7};
        set_rows(0, 0, 0);
        w_rom[1*L+3] = 1;
        run_case("s6", 0);

        // All-negative scores, maximum in the middle
        act = '{1, 1, 1, 1};
        set_rows(-3, -1, -2);
        run_case("neg", 0);

        // Scenario 3: default-size instance, worst-case negative products
        b_fmap = '1;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 1;
        while (!b_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("s3_latency", n, 10021);
        for (int c = 0; c < BC; c++) begin
            check($sformatf("s3_score%0d", c), longint'($signed(b_dout[c*ACC +: ACC])), 255 * -128 * 1000);
        end
        check("s3_class", b_pcls, 0);
        @(negedge clk);
        check("s3_done_pulse", b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
